uart_msg_sequencer: RTL and testbench
=====================================

# uart_msg_sequencer

Parametrised Wishbone bus master that programs the UART baud register once, then repeatedly transmits a MSG_LEN-byte message held in an internal, run-time-writable byte array, with a configurable gap between messages. It replaces the fixed three-character control sequencer. New behaviour over that sequencer:
- real ack/err/rty handshaking with bounded retry, timeout and status-poll limits;
- run/stop control;
- busy/done/error status outputs.

It sits between the top level and the UART register slave on the shared Wishbone bus.

## Interface
Parameters:
- MSG_LEN, 3: message length in bytes, 1..256.
- MSG_INIT, {8'h55,8'h52,8'h41}: reset contents of the message array, packed; byte 0 in bits [7:0].
- BAUD_WORD, 32'h1d7dbf5a: value written to the baud register.
- PERIOD_CYCLES, 32'd1000000: idle gap after each message. 0 means no gap.
- TIMEOUT_CYCLES, 16'd255: maximum number of cycles stb_o may wait for a response.
- RETRY_MAX, 3: number of rty_i responses tolerated per transaction.
- POLL_MAX, 16'd65535: maximum number of status reads per byte.

Ports (name, direction, width, meaning):
- clk_i  in  1  system clock. All logic is clocked on its rising edge.
- async_rst_i  in  1  asynchronous, active-low reset.
- run_i  in  1  level. While high, messages are sent continuously.
- clr_err_i  in  1  one-cycle pulse that leaves the ERROR state.
- msg_we_i, msg_addr_i [AW-1:0] (AW = max(1, clog2(MSG_LEN))), msg_dat_i [7:0]  in  message array write port.
- addr_o, dat_o  out  32  Wishbone address and write data.
- dat_i  in  32  Wishbone read data.
- we_o, cyc_o, stb_o  out  1  Wishbone controls.
- sel_o  out  4  byte selects. Always 4'hF.
- lock_o  out  1  always 0.
- ack_i, err_i, rty_i  in  1  Wishbone slave responses.
- tagn_i  in  1  unused.
- tagn_o  out  1  unused, driven 0.
- busy_o  out  1  high in every state except IDLE and ERROR.
- done_o  out  1  one-cycle pulse when a message completes.
- err_o  out  1  sticky error flag.
- out_led  out  10  byte currently being sent, zero-extended.

## Operation
UART register map:
- 0x4: baud register.
- 0x7: TX buffer.
- 0x3: control register. Writing 0x80 starts transmission.
- 0x5: status register. Bit 5 = TX complete. Writing 0 clears it.

State machine:
- IDLE → BAUD when run_i=1. This happens only on the first run after reset.
- IDLE → TXBUF when run_i=1 on any later run.
- BAUD: write BAUD_WORD to 0x4, then → TXBUF.
- TXBUF: latch the byte at msg[idx] into out_led, write it to 0x7, then → START.
- START: write 0x80 to 0x3, then → POLL.
- POLL: read 0x5.
  - If dat_i[5]=1 on the ack cycle → CLR.
  - Otherwise, re-read after one idle cycle.
  - The POLL_MAX-th read returning 0 → ERROR.
- CLR: write 0 to 0x5.
  - If idx < MSG_LEN-1: idx++ and → TXBUF.
  - Otherwise: pulse done_o, set idx=0, → DELAY.
- DELAY: count PERIOD_CYCLES cycles.
  - At terminal count: → TXBUF if run_i=1, else → IDLE.
  - With PERIOD_CYCLES=0, go straight to the TXBUF/IDLE decision.
- ERROR: bus idle, err_o=1.
  - On clr_err_i: idx=0, err_o=0, → IDLE.
  - The baud register is rewritten on the next run.

Run/stop and message writes:
- run_i falling mid-message does not abort. The current message finishes, then the block stops at the DELAY/IDLE decision.
- A msg_we_i write lands on the next edge in every state. It affects transmission only if it is written before its byte is latched in TXBUF.
- Writes with msg_addr_i ≥ MSG_LEN are ignored.

## Timing
Reset values (async_rst_i=0, applied immediately):
- All Wishbone outputs 0.
- busy_o, done_o, err_o = 0.
- out_led = 0.
- idx = 0. Message array = MSG_INIT.
- State = IDLE, baud-written flag cleared.

Transaction handshake:
- cyc_o, stb_o, addr_o, dat_o and we_o assert together on the cycle after the state is entered.
- They are held stable until ack_i, err_i or rty_i is sampled high.
- They drop on the following cycle. There is at least one idle bus cycle between transactions.

Response handling:
- ack_i: the transaction completes.
- rty_i: drop for one cycle, then reissue the identical transaction. The (RETRY_MAX+1)-th rty_i → ERROR.
- err_i: → ERROR.
- No response within TIMEOUT_CYCLES cycles of stb_o rising: abort, drop cyc/stb, → ERROR.
- Simultaneous responses are prioritised err_i > ack_i > rty_i.

Latency:
- With a zero-wait slave and status returning 1 on the first read, each byte takes 4 transactions at 2 cycles each = 8 cycles.
- The baud write adds 2 cycles once.

Counter widths:
- The timeout counter resets each transaction.
- The poll counter resets at TXBUF.
- The delay counter is 32-bit, starts at 0 and must not wrap.

## Test plan
1. Reset, run_i=1, zero-wait ack, status=0x20.
   - Bus sequence: W4=0x1d7dbf5a; then W7=0x41, W3=0x80, R5, W5=0.
   - The same per-byte sequence repeats for 0x52 and 0x55.
   - done_o pulses once; out_led steps 0x041, 0x052, 0x055.
2. Status returns 0 three times, then 0x20 → exactly 4 reads of 0x5 for that byte, each separated by one idle cycle.
3. rty_i asserted on the first two attempts of W7, ack on the third → identical addr/data reissued and normal completion. Four rty_i responses → err_o=1 and the state machine stays in ERROR; after clr_err_i, the next run rewrites 0x4.
4. Slave never responds → stb_o drops TIMEOUT_CYCLES+1 cycles after rising and err_o=1.
5. async_rst_i pulsed low while stb_o=1 → all outputs reach reset values without a clock edge. The restart rewrites the baud register.
6. Write 0x5A to address 1 during byte 0, then drop run_i → the second byte sent is 0x5A, the message completes with done_o, and the block returns to IDLE with busy_o=0.

Source files
------------

// File: rtl/uart_msg_sequencer.sv
// Wishbone master that programs the UART baud register once, then repeatedly sends
// a run-time-writable MSG_LEN-byte message with bounded retry, timeout and status polling.
module uart_msg_sequencer #(
  parameter int unsigned                 MSG_LEN        = 3,
  parameter logic [MSG_LEN*8-1:0]        MSG_INIT       = {8'h55, 8'h52, 8'h41},
  parameter logic [31:0]                 BAUD_WORD      = 32'h1d7dbf5a,
  parameter logic [31:0]                 PERIOD_CYCLES  = 32'd1000000,
  parameter logic [15:0]                 TIMEOUT_CYCLES = 16'd255,
  parameter int unsigned                 RETRY_MAX      = 3,
  parameter logic [15:0]                 POLL_MAX       = 16'd65535,
  localparam int unsigned                AW             = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk_i,
  input  logic          async_rst_i,
  input  logic          run_i,
  input  logic          clr_err_i,
  input  logic          msg_we_i,
  input  logic [AW-1:0] msg_addr_i,
  input  logic [7:0]    msg_dat_i,
  output logic [31:0]   addr_o,
  output logic [31:0]   dat_o,
  input  logic [31:0]   dat_i,
  output logic          we_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic [3:0]    sel_o,
  output logic          lock_o,
  input  logic          ack_i,
  input  logic          err_i,
  input  logic          rty_i,
  input  logic          tagn_i,
  output logic          tagn_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [9:0]    out_led
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BAUD,
    S_TXBUF,
    S_START,
    S_POLL,
    S_CLR,
    S_DELAY,
    S_ERROR
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(MSG_LEN - 1);

  state_t        r_state, w_state_next;
  logic          r_cyc, w_cyc_next;
  logic          r_we, w_we_next;
  logic [31:0]   r_addr, w_addr_next;
  logic [31:0]   r_dat, w_dat_next;
  logic [AW-1:0] r_idx, w_idx_next;
  logic [15:0]   r_tmo, w_tmo_next;
  logic [31:0]   r_rty, w_rty_next;
  logic [15:0]   r_poll, w_poll_next;
  logic [31:0]   r_dly, w_dly_next;
  logic          r_baud_done, w_baud_done_next;
  logic          r_err, w_err_next;
  logic          r_done, w_done_next;
  logic [9:0]    r_led, w_led_next;

  logic [7:0]    w_msg [MSG_LEN];
  logic [7:0]    w_tx_byte;
  logic [31:0]   w_req_addr;
  logic [31:0]   w_req_dat;
  logic          w_req_we;
  logic          w_go_error;
  logic          w_unused;

  assign w_unused = ^{tagn_i, dat_i[31:6], dat_i[4:0]};

  // Each message byte is its own register so it can carry a reset value.
  for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_msg
    logic [7:0] r_byte;
    always_ff @(posedge clk_i or negedge async_rst_i) begin
      if (!async_rst_i) begin
        r_byte <= MSG_INIT[gi*8 +: 8];
      end else if (msg_we_i && (msg_addr_i == AW'(gi))) begin
        r_byte <= msg_dat_i;
      end
    end
    assign w_msg[gi] = r_byte;
  end

  // A retried TX write must resend the byte captured on the first attempt.
  assign w_tx_byte = (r_rty == 32'd0) ? w_msg[r_idx] : r_led[7:0];

  always_comb begin
    w_req_addr = 32'h0;
    w_req_dat  = 32'h0;
    w_req_we   = 1'b1;
    case (r_state)
      S_BAUD:  begin w_req_addr = 32'h4; w_req_dat = BAUD_WORD; end
      S_TXBUF: begin w_req_addr = 32'h7; w_req_dat = {24'h0, w_tx_byte}; end
      S_START: begin w_req_addr = 32'h3; w_req_dat = 32'h80; end
      S_POLL:  begin w_req_addr = 32'h5; w_req_we = 1'b0; end
      S_CLR:   begin w_req_addr = 32'h5; end
      default: begin w_req_we = 1'b0; end
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_cyc_next       = r_cyc;
    w_we_next        = r_we;
    w_addr_next      = r_addr;
    w_dat_next       = r_dat;
    w_idx_next       = r_idx;
    w_tmo_next       = r_tmo;
    w_rty_next       = r_rty;
    w_poll_next      = r_poll;
    w_dly_next       = r_dly;
    w_baud_done_next = r_baud_done;
    w_err_next       = r_err;
    w_done_next      = 1'b0;
    w_led_next       = r_led;
    w_go_error       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run_i) begin
          w_state_next = r_baud_done ? S_TXBUF : S_BAUD;
        end
      end
      S_DELAY: begin
        if (r_dly == PERIOD_CYCLES - 32'd1) begin
          w_dly_next   = 32'd0;
          w_state_next = run_i ? S_TXBUF : S_IDLE;
        end else begin
          w_dly_next = r_dly + 32'd1;
        end
      end
      S_ERROR: begin
        if (clr_err_i) begin
          w_idx_next   = '0;
          w_err_next   = 1'b0;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        if (!r_cyc) begin
          w_cyc_next  = 1'b1;
          w_we_next   = w_req_we;
          w_addr_next = w_req_addr;
          w_dat_next  = w_req_dat;
          w_tmo_next  = 16'd0;
          if (r_state == S_TXBUF) begin
            w_led_next  = {2'b00, w_tx_byte};
            w_poll_next = 16'd0;
          end
        end else if (err_i) begin
          w_go_error = 1'b1;
        end else if (ack_i) begin
          w_cyc_next  = 1'b0;
          w_we_next   = 1'b0;
          w_addr_next = 32'h0;
          w_dat_next  = 32'h0;
          w_rty_next  = 32'd0;
          case (r_state)
            S_BAUD: begin
              w_baud_done_next = 1'b1;
              w_state_next     = S_TXBUF;
            end
            S_TXBUF: w_state_next = S_START;
            S_START: w_state_next = S_POLL;
            S_POLL: begin
              if (dat_i[5]) begin
                w_state_next = S_CLR;
              end else if (({1'b0, r_poll} + 17'd1) >= {1'b0, POLL_MAX}) begin
                w_go_error = 1'b1;
              end else begin
                w_poll_next = r_poll + 16'd1;
              end
            end
            S_CLR: begin
              if (r_idx != LAST_IDX) begin
                w_idx_next   = r_idx + AW'(1);
                w_state_next = S_TXBUF;
              end else begin
                w_done_next = 1'b1;
                w_idx_next  = '0;
                w_dly_next  = 32'd0;
                if (PERIOD_CYCLES == 32'd0) begin
                  w_state_next = run_i ? S_TXBUF : S_IDLE;
                end else begin
                  w_state_next = S_DELAY;
                end
              end
            end
            default: w_state_next = r_state;
          endcase
        end else if (rty_i) begin
          w_cyc_next  = 1'b0;
          w_we_next   = 1'b0;
          w_addr_next = 32'h0;
          w_dat_next  = 32'h0;
          if (r_rty == RETRY_MAX) begin
            w_go_error = 1'b1;
          end else begin
            w_rty_next = r_rty + 32'd1;
          end
        end else if (r_tmo == TIMEOUT_CYCLES) begin
          w_go_error = 1'b1;
        end else begin
          w_tmo_next = r_tmo + 16'd1;
        end
      end
    endcase

    // Any bus failure forces a fresh baud write on the next run.
    if (w_go_error) begin
      w_state_next     = S_ERROR;
      w_err_next       = 1'b1;
      w_cyc_next       = 1'b0;
      w_we_next        = 1'b0;
      w_addr_next      = 32'h0;
      w_dat_next       = 32'h0;
      w_rty_next       = 32'd0;
      w_baud_done_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_dat       <= 32'h0;
      r_idx       <= '0;
      r_tmo       <= 16'd0;
      r_rty       <= 32'd0;
      r_poll      <= 16'd0;
      r_dly       <= 32'd0;
      r_baud_done <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_led       <= 10'd0;
    end else begin
      r_cyc       <= w_cyc_next;
      r_we        <= w_we_next;
      r_addr      <= w_addr_next;
      r_dat       <= w_dat_next;
      r_idx       <= w_idx_next;
      r_tmo       <= w_tmo_next;
      r_rty       <= w_rty_next;
      r_poll      <= w_poll_next;
      r_dly       <= w_dly_next;
      r_baud_done <= w_baud_done_next;
      r_err       <= w_err_next;
      r_done      <= w_done_next;
      r_led       <= w_led_next;
    end
  end

  assign cyc_o   = r_cyc;
  assign stb_o   = r_cyc;
  assign we_o    = r_we;
  assign addr_o  = r_addr;
  assign dat_o   = r_dat;
  assign sel_o   = 4'hF;
  assign lock_o  = 1'b0;
  assign tagn_o  = 1'b0;
  assign busy_o  = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign done_o  = r_done;
  assign err_o   = r_err;
  assign out_led = r_led;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Directed bench: a behavioural Wishbone slave logs every transaction and the
// initial block compares the log against hand-written expected bus sequences.
module tb_uart_msg_sequencer;
  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        async_rst_i = 1'b0;
  logic        run_i = 1'b0;
  logic        clr_err_i = 1'b0;
  logic        msg_we_i = 1'b0;
  logic [1:0]  msg_addr_i = 2'd0;
  logic [7:0]  msg_dat_i = 8'h0;
  logic [31:0] dat_i = 32'h0;
  logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0, tagn_i = 1'b0;
  logic [31:0] addr_o, dat_o;
  logic        we_o, cyc_o, stb_o, lock_o, tagn_o, busy_o, done_o, err_o;
  logic [3:0]  sel_o;
  logic [9:0]  out_led;

  uart_msg_sequencer #(
    .PERIOD_CYCLES (32'd4),
    .TIMEOUT_CYCLES(16'(TMO)),
    .RETRY_MAX     (3),
    .POLL_MAX      (16'd6)
  ) dut (
    .clk_i(clk_i), .async_rst_i(async_rst_i), .run_i(run_i), .clr_err_i(clr_err_i),
    .msg_we_i(msg_we_i), .msg_addr_i(msg_addr_i), .msg_dat_i(msg_dat_i),
    .addr_o(addr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .cyc_o(cyc_o),
    .stb_o(stb_o), .sel_o(sel_o), .lock_o(lock_o), .ack_i(ack_i), .err_i(err_i),
    .rty_i(rty_i), .tagn_i(tagn_i), .tagn_o(tagn_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .out_led(out_led)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dat;
    logic        we;
    int          cyc;
    logic [9:0]  led;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  txn_t        mon_t;
  int          cyc_cnt = 0;
  int          fall_cyc = 0;
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        prev_stb = 1'b0;
  bit          silent = 1'b0;
  bit          err_next = 1'b0;
  int          rty_left = 0;
  int          zero_left = 0;
  logic [31:0] rty_addr = 32'h7;

  always @(posedge clk_i) cyc_cnt++;

  // Slave responds in the same cycle stb_o is seen; inputs change on the falling edge.
  always @(negedge clk_i) begin
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = 32'h0;
    if (stb_o && !prev_stb) begin
      mon_t.addr = addr_o; mon_t.dat = dat_o; mon_t.we = we_o;
      mon_t.cyc = cyc_cnt; mon_t.led = out_led;
      log_q.push_back(mon_t);
    end
    if (!stb_o && prev_stb) fall_cyc = cyc_cnt;
    prev_stb = stb_o;
    if (done_o) done_cnt++;
    if (stb_o && !silent) begin
      if (err_next) begin
        err_i = 1'b1; err_next = 1'b0;
      end else if (rty_left > 0 && addr_o == rty_addr) begin
        rty_i = 1'b1; rty_left--;
      end else begin
        ack_i = 1'b1;
        if (!we_o && addr_o == 32'h5) begin
          if (zero_left > 0) zero_left--;
          else dat_i = 32'h20;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [31:0] d, input logic w);
    txn_t t;
    t.addr = a; t.dat = d; t.we = w; t.cyc = 0; t.led = 10'd0;
    exp_q.push_back(t);
  endtask

  task automatic exp_byte(input logic [7:0] b, input int nzero);
    exp_push(32'h7, {24'h0, b}, 1'b1);
    exp_push(32'h3, 32'h80, 1'b1);
    for (int i = 0; i <= nzero; i++) exp_push(32'h5, 32'h0, 1'b0);
    exp_push(32'h5, 32'h0, 1'b1);
  endtask

  task automatic exp_msg(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input bit baud);
    exp_q.delete();
    if (baud) exp_push(32'h4, 32'h1d7dbf5a, 1'b1);
    exp_byte(b0, 0);
    exp_byte(b1, 0);
    exp_byte(b2, 0);
  endtask

  task automatic compare_log(input string tag);
    int n;
    check_eq({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), log_q[i].addr, exp_q[i].addr);
      check_eq($sformatf("%s_dat%0d", tag, i), log_q[i].dat, exp_q[i].dat);
      check_eq($sformatf("%s_we%0d", tag, i), 32'(log_q[i].we), 32'(exp_q[i].we));
      if (exp_q[i].addr == 32'h7)
        check_eq($sformatf("%s_led%0d", tag, i), 32'(log_q[i].led), 32'(exp_q[i].dat[9:0]));
    end
  endtask

  task automatic start_run();
    log_q.delete();
    run_i = 1'b1;
    @(negedge clk_i);
    run_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && busy_o; i++) @(negedge clk_i);
    check_eq(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_err(input string tag);
    for (int i = 0; i < 400 && !err_o; i++) @(negedge clk_i);
    check_eq(tag, 32'(err_o), 32'd1);
  endtask

  task automatic clear_err(input string tag);
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    check_eq(tag, 32'(err_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cyc"}, 32'(cyc_o), 32'd0);
    check_eq({tag, "_stb"}, 32'(stb_o), 32'd0);
    check_eq({tag, "_we"}, 32'(we_o), 32'd0);
    check_eq({tag, "_addr"}, addr_o, 32'h0);
    check_eq({tag, "_dat"}, dat_o, 32'h0);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_done"}, 32'(done_o), 32'd0);
    check_eq({tag, "_err"}, 32'(err_o), 32'd0);
    check_eq({tag, "_led"}, 32'(out_led), 32'd0);
  endtask

  initial begin
    int d0;
    int rise;
    repeat (2) @(negedge clk_i);
    check_reset_outputs("rst");
    check_eq("rst_sel", 32'(sel_o), 32'hF);
    check_eq("rst_lock", 32'(lock_o), 32'd0);
    check_eq("rst_tagn", 32'(tagn_o), 32'd0);
    async_rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("rst_idle_busy", 32'(busy_o), 32'd0);

    // Baud write plus three bytes with a zero-wait slave.
    d0 = done_cnt;
    start_run();
    check_eq("t1_busy", 32'(busy_o), 32'd1);
    wait_idle("t1_idle");
    exp_msg(8'h41, 8'h52, 8'h55, 1'b1);
    compare_log("t1");
    check_eq("t1_done", 32'(done_cnt - d0), 32'd1);
    if (log_q.size() == 13)
      for (int i = 1; i < 13; i++)
        check_eq($sformatf("t1_gap%0d", i), 32'(log_q[i].cyc - log_q[i-1].cyc), 32'd2);

    // Three zero status reads before TX complete on byte 0.
    zero_left = 3;
    d0 = done_cnt;
    start_run();
    wait_idle("t2_idle");
    exp_q.delete();
    exp_byte(8'h41, 3);
    exp_byte(8'h52, 0);
    exp_byte(8'h55, 0);
    compare_log("t2");
    check_eq("t2_done", 32'(done_cnt - d0), 32'd1);
    if (log_q.size() >= 6)
      for (int i = 3; i < 6; i++)
        check_eq($sformatf("t2_pollgap%0d", i), 32'(log_q[i].cyc - log_q[i-1].cyc), 32'd2);

    // Status never sets: the sixth zero read ends in ERROR.
    zero_left = 100;
    start_run();
    wait_err("t2b_err");
    exp_q.delete();
    exp_push(32'h7, 32'h41, 1'b1);
    exp_push(32'h3, 32'h80, 1'b1);
    for (int i = 0; i < 6; i++) exp_push(32'h5, 32'h0, 1'b0);
    compare_log("t2b");
    check_eq("t2b_busy", 32'(busy_o), 32'd0);
    zero_left = 0;
    clear_err("t2b_clr");

    // Two retries on the TX write, then success; baud is rewritten after the error.
    rty_addr = 32'h7;
    rty_left = 2;
    start_run();
    wait_idle("t3a_idle");
    exp_q.delete();
    exp_push(32'h4, 32'h1d7dbf5a, 1'b1);
    exp_push(32'h7, 32'h41, 1'b1);
    exp_push(32'h7, 32'h41, 1'b1);
    exp_byte(8'h41, 0);
    exp_byte(8'h52, 0);
    exp_byte(8'h55, 0);
    compare_log("t3a");
    check_eq("t3a_err", 32'(err_o), 32'd0);
    if (log_q.size() >= 3)
      check_eq("t3a_rtygap", 32'(log_q[2].cyc - log_q[1].cyc), 32'd2);

    // Four retries exceed RETRY_MAX=3.
    rty_left = 4;
    start_run();
    wait_err("t3b_err");
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_push(32'h7, 32'h41, 1'b1);
    compare_log("t3b");
    repeat (5) @(negedge clk_i);
    check_eq("t3b_stay_err", 32'(err_o), 32'd1);
    check_eq("t3b_stay_busy", 32'(busy_o), 32'd0);
    check_eq("t3b_stay_cyc", 32'(cyc_o), 32'd0);
    rty_left = 0;
    clear_err("t3b_clr");
    start_run();
    wait_idle("t3c_idle");
    exp_msg(8'h41, 8'h52, 8'h55, 1'b1);
    compare_log("t3c");

    // Silent slave: stb_o drops TMO+1 cycles after rising.
    silent = 1'b1;
    start_run();
    wait_err("t4_err");
    @(negedge clk_i);
    check_eq("t4_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) begin
      rise = log_q[0].cyc;
      check_eq("t4_addr", log_q[0].addr, 32'h7);
      check_eq("t4_tmo", 32'(fall_cyc - rise), 32'(TMO + 1));
    end
    check_eq("t4_stb", 32'(stb_o), 32'd0);
    silent = 1'b0;
    clear_err("t4_clr");

    // Asynchronous reset while a transaction is outstanding.
    silent = 1'b1;
    start_run();
    for (int i = 0; i < 10 && !stb_o; i++) @(negedge clk_i);
    check_eq("t5_stb_up", 32'(stb_o), 32'd1);
    #2 async_rst_i = 1'b0;
    #1 check_reset_outputs("t5_rst");
    async_rst_i = 1'b1;
    silent = 1'b0;
    @(negedge clk_i);
    start_run();
    wait_idle("t5_idle");
    exp_msg(8'h41, 8'h52, 8'h55, 1'b1);
    compare_log("t5");

    // Rewrite byte 1 during byte 0 with run_i already low.
    d0 = done_cnt;
    start_run();
    msg_we_i = 1'b1; msg_addr_i = 2'd1; msg_dat_i = 8'h5A;
    @(negedge clk_i);
    msg_we_i = 1'b0;
    wait_idle("t6_idle");
    exp_msg(8'h41, 8'h5A, 8'h55, 1'b0);
    compare_log("t6");
    check_eq("t6_done", 32'(done_cnt - d0), 32'd1);

    // Bus error on the first transaction.
    err_next = 1'b1;
    start_run();
    wait_err("t7_err");
    exp_q.delete();
    exp_push(32'h7, 32'h41, 1'b1);
    compare_log("t7");
    clear_err("t7_clr");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
